// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/result bundle for the iterative multiply/divide unit
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, A, B,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start, op, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32x32 multiply/divide; divider built only with MULT_DIV_UNIT_DIVIDE_EN
module mult_div_unit (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic        op_ok;
    logic        accept;
    logic        in_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mplier;
    logic [63:0] mcand;
    logic [63:0] acc;
    logic [63:0] prod_fix;

    // op[0]=0 selects the signed variants; operands are converted to magnitudes on entry
    assign in_signed = ~bus.op[0];
    assign a_mag     = (in_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign b_mag     = (in_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~bus.op[1];
`endif

    assign accept   = bus.start && op_ok && ((state == IDLE) || (state == DONE));
    assign prod_fix = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and status outputs; busy covers CALC and FIX, done marks the result cycle
    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = accept ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // iteration counter; wraps 31->0 on the last CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 5'd0;
        end else if (accept) begin
            count <= 5'd0;
        end else if (state == CALC) begin
            count <= count + 5'd1;
        end
    end

    // shift-add multiplier on magnitudes; steps every CALC cycle regardless of op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mplier <= 32'd0;
            mcand  <= 64'd0;
            acc    <= 64'd0;
        end else if (accept) begin
            neg_a  <= in_signed & bus.A[31];
            neg_b  <= in_signed & bus.B[31];
            mplier <= a_mag;
            mcand  <= {32'd0, b_mag};
            acc    <= 64'd0;
        end else if (state == CALC) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
        end
    end

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    logic        op_div;
    logic [31:0] a_raw;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // rem < divisor holds between steps, so trial[32] is a true borrow flag
    assign rem_shift = {rem, quo[31]};
    assign trial     = rem_shift - {1'b0, divisor};
    assign ge        = ~trial[32];
    assign quo_fix   = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
    assign rem_fix   = neg_a ? (~rem + 32'd1) : rem;

    // restoring divider on magnitudes; dividend shifts out of quo as quotient bits shift in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div  <= 1'b0;
            a_raw   <= 32'd0;
            divisor <= 32'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
        end else if (accept) begin
            op_div  <= bus.op[1];
            a_raw   <= bus.A;
            divisor <= b_mag;
            quo     <= a_mag;
            rem     <= 32'd0;
        end else if (state == CALC) begin
            rem <= ge ? trial[31:0] : rem_shift[31:0];
            quo <= {quo[30:0], ge};
        end
    end
`endif

    // result registers: written once in FIX, held otherwise; div_zero drops on a new accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.HI       <= 32'd0;
            bus.LO       <= 32'd0;
            bus.div_zero <= 1'b0;
        end else if (accept) begin
            bus.div_zero <= 1'b0;
        end else if (state == FIX) begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            if (op_div) begin
                if (divisor == 32'd0) begin
                    bus.HI       <= a_raw;
                    bus.LO       <= 32'hFFFF_FFFF;
                    bus.div_zero <= 1'b1;
                end else begin
                    bus.HI <= rem_fix;
                    bus.LO <= quo_fix;
                end
            end else begin
                bus.HI <= prod_fix[63:32];
                bus.LO <= prod_fix[31:0];
            end
`else
            bus.HI <= prod_fix[63:32];
            bus.LO <= prod_fix[31:0];
`endif
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;
    logic        last_dz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit op_supported(input logic [1:0] o);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        return 1'b1;
`else
        return ~o[1];
`endif
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        int          sq;
        int          sr;
        e.dz  = 1'b0;
        e.cyc = 0;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = sp;
            end
            2'b01: begin
                up = 64'(a) * 64'(b);
                {e.hi, e.lo} = up;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0; e.lo = 32'h8000_0000;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.lo = sq;
                    e.hi = sr;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // present start for one cycle; an accepted op gets its result and done cycle queued
    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        if (push) begin
            e       = model(o, a, b);
            e.cyc   = cyc + 34;
            last_hi = e.hi;
            last_lo = e.lo;
            last_dz = e.dz;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = cyc;
        if (op_supported(o)) begin
            drive(o, a, b, 1'b1);
            check("busy_after_start", 64'(bus.busy), 64'd1);
            wait_until(k + 35);
        end else begin
            drive(o, a, b, 1'b0);
            check("ignored_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
            check("ignored_hi", 64'(bus.HI), 64'(last_hi));
            check("ignored_lo", 64'(bus.LO), 64'(last_lo));
            check("ignored_dz", 64'(bus.div_zero), 64'(last_dz));
        end
    endtask

    // monitor: every done pops one expectation; an expectation past its cycle is a missed done
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("hi", 64'(bus.HI), 64'(e.hi));
                    check("lo", 64'(bus.LO), 64'(e.lo));
                    check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                    check("busy_in_done", 64'(bus.busy), 64'd0);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                check("done_missing", 64'd0, 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int          k;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        cyc       = 0;
        n_checks  = 0;
        n_pass    = 0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;
        last_dz   = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(bus.HI), 64'd0);
        check("reset_lo", 64'(bus.LO), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dz", 64'(bus.div_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // reset in the middle of an operation discards it
        k = cyc;
        drive(2'b01, 32'd6, 32'd7, 1'b0);
        wait_until(k + 10);
        #2 rst = 1'b1;
        #1;
        check("midrst_hi", 64'(bus.HI), 64'd0);
        check("midrst_lo", 64'(bus.LO), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_dz", 64'(bus.div_zero), 64'd0);
        sb.delete();
        last_hi = 32'd0;
        last_lo = 32'd0;
        last_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd3, 32'd5);

        // start pulses while busy are ignored
        k = cyc;
        drive(2'b01, 32'd1000, 32'd3, 1'b1);
        wait_until(k + 5);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(k + 35);

        // start held during the done cycle launches the next op with no gap
        k = cyc;
        drive(2'b00, 32'hFFFF_FFFB, 32'd9, 1'b1);
        wait_until(k + 34);
        drive(2'b01, 32'd123, 32'd456, 1'b1);
        wait_until(k + 69);

        // randomized operations across all ops
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom);
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            run_op(o, a, b);
        end

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-004 SHALL have ports: op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have ports: A  input  32  operand 1, driven from register-bank output DR1.
REQ-006 SHALL have ports: B  input  32  operand 2, driven from register-bank output DR2.
REQ-007 SHALL have ports: HI  output  32  upper product or remainder; registered.
REQ-008 SHALL have ports: LO  output  32  lower product or quotient; registered.
REQ-009 SHALL have ports: busy  output  1  operation in progress.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse; HI and LO hold the new result in that cycle.
REQ-011 SHALL have ports: div_zero  output  1  registered; set with done when the divisor was 0.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-013 SHALL, in IDLE or DONE, accept start=1: latch op, A and B and go to CALC; A and B may change afterwards without effect.
REQ-014 SHALL ignore start while busy=1; the operation in progress continues unaffected.
REQ-015 SHALL, in CALC, perform one iteration per cycle for exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 and then moves to FIX.
REQ-016 SHALL, for multiply, use shift-add on operand magnitudes with a 64-bit accumulator.
REQ-017 SHALL, for divide, use restoring division on magnitudes, with a 32-bit quotient and a 33-bit partial remainder.
REQ-018 SHALL, in FIX, apply sign correction and write HI/LO:
- signed multiply: negate the 64-bit product when the operand signs differ;
- signed divide: quotient negative when the signs differ; remainder takes the sign of the dividend.
REQ-019 SHALL use the state after FIX as DONE: done=1 and busy=0 for one cycle, then IDLE unless start=1.
REQ-020 SHALL give a latency of start-edge to done-high of 34 cycles; busy=1 exactly in CALC and FIX (33 cycles).
REQ-021 SHALL, when B=0 on divide: run the full 34-cycle timing, set HI=A (dividend) and LO=32'hFFFFFFFF, and set div_zero=1 with done.
REQ-022 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF: set LO=32'h80000000, HI=0, and div_zero=0.
REQ-023 SHALL hold HI, LO and div_zero until the next FIX/DONE writes them; div_zero is cleared when the next operation is accepted.
REQ-024 SHALL, when start=1 in DONE, start a back-to-back operation with no idle cycle.

Reset
REQ-025 SHALL, on rst=1, immediately force IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0 and counter=0, independent of clk.
REQ-026 SHALL, on reset mid-operation, discard the partial result; the first start after reset release is accepted normally.

Configuration
REQ-027 SHALL, with macro MULT_DIV_UNIT_DIVIDE_EN defined, include the divider datapath and support all four ops.
REQ-028 SHALL, without MULT_DIV_UNIT_DIVIDE_EN:
- omit the divider logic;
- ignore start with op=10/11: stays IDLE, no busy, no done, HI/LO/div_zero unchanged;
- run multiply ops unchanged.

Verification
REQ-029 SHALL cover: MULTU A=32'hFFFFFFFF, B=2 -> done at cycle 34, HI=1, LO=32'hFFFFFFFE.
REQ-030 SHALL cover: MULT A=-3, B=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB (-21).
REQ-031 SHALL cover: DIV A=-7, B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1), div_zero=0; with the macro undefined, the same stimulus -> no busy/done, HI/LO unchanged.
REQ-032 SHALL cover: DIVU A=100, B=0 -> HI=100, LO=32'hFFFFFFFF, div_zero=1, done at cycle 34.
REQ-033 SHALL cover: start MULTU 6x7, assert rst at cycle 10, release, then start MULTU 3x5 -> no done for the first op, outputs 0 during reset, second op gives LO=15, HI=0 after 34 cycles.
REQ-034 SHALL cover: start pulses at cycle 5 while busy are ignored; start held high in the DONE cycle -> back-to-back op with done 34 cycles later.
